// File: rtl/cu_pkg.sv
// cu_pkg
//   Shared definitions for the control unit: state encodings, opcode values,
//   control-word field positions, bus source codes and ALU operation codes.
//   Control word layout (21 bits):
//     [20:17] bus_sel  [16] AR_we [15] PC_we [14] DR_we [13] IR_we [12] AC_we
//     [11] R1_we [10] R2_we [9] TR_we [8] mem_rd [7] mem_wr [6] pc_inc
//     [5] ar_inc [4:2] alu_op [1] ac_src_alu [0] halt
package cu_pkg;

  localparam int WORD_W = 21;
  localparam int OP_W   = 8;
  localparam int STATE_W = 5;

  // Sequencer states
  localparam logic [STATE_W-1:0] S_START  = 5'd0;
  localparam logic [STATE_W-1:0] S_FETCH1 = 5'd1;
  localparam logic [STATE_W-1:0] S_FETCH2 = 5'd2;
  localparam logic [STATE_W-1:0] S_FETCH3 = 5'd3;
  localparam logic [STATE_W-1:0] S_DECODE = 5'd4;
  localparam logic [STATE_W-1:0] S_LD1    = 5'd5;
  localparam logic [STATE_W-1:0] S_LD2    = 5'd6;
  localparam logic [STATE_W-1:0] S_LD3    = 5'd7;
  localparam logic [STATE_W-1:0] S_LD4    = 5'd8;
  localparam logic [STATE_W-1:0] S_LD5    = 5'd9;
  localparam logic [STATE_W-1:0] S_ST1    = 5'd10;
  localparam logic [STATE_W-1:0] S_ST2    = 5'd11;
  localparam logic [STATE_W-1:0] S_ST3    = 5'd12;
  localparam logic [STATE_W-1:0] S_ST4    = 5'd13;
  localparam logic [STATE_W-1:0] S_ST5    = 5'd14;
  localparam logic [STATE_W-1:0] S_MVACR1 = 5'd15;
  localparam logic [STATE_W-1:0] S_MVR1AC = 5'd16;
  localparam logic [STATE_W-1:0] S_ADD    = 5'd17;
  localparam logic [STATE_W-1:0] S_SUB    = 5'd18;
  localparam logic [STATE_W-1:0] S_INCAC  = 5'd19;
  localparam logic [STATE_W-1:0] S_CLAC   = 5'd20;
  localparam logic [STATE_W-1:0] S_JMP1   = 5'd21;
  localparam logic [STATE_W-1:0] S_JMP2   = 5'd22;
  localparam logic [STATE_W-1:0] S_JMP3   = 5'd23;
  localparam logic [STATE_W-1:0] S_HALT   = 5'd24;

  // Opcodes held in IR
  localparam logic [OP_W-1:0] OP_NOP    = 8'h00;
  localparam logic [OP_W-1:0] OP_LDAC   = 8'h01;
  localparam logic [OP_W-1:0] OP_STAC   = 8'h02;
  localparam logic [OP_W-1:0] OP_MVACR1 = 8'h03;
  localparam logic [OP_W-1:0] OP_MVR1AC = 8'h04;
  localparam logic [OP_W-1:0] OP_ADD    = 8'h05;
  localparam logic [OP_W-1:0] OP_SUB    = 8'h06;
  localparam logic [OP_W-1:0] OP_INCAC  = 8'h07;
  localparam logic [OP_W-1:0] OP_CLAC   = 8'h08;
  localparam logic [OP_W-1:0] OP_JUMP   = 8'h09;
  localparam logic [OP_W-1:0] OP_END    = 8'hFF;

  // Bus source codes (values 7-15 are reserved and never produced)
  localparam logic [3:0] BUS_NONE = 4'd0;
  localparam logic [3:0] BUS_PC   = 4'd1;
  localparam logic [3:0] BUS_DR   = 4'd2;
  localparam logic [3:0] BUS_AC   = 4'd3;
  localparam logic [3:0] BUS_R1   = 4'd4;
  localparam logic [3:0] BUS_AR   = 4'd5;
  localparam logic [3:0] BUS_MEM  = 4'd6;

  // ALU operation codes
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_INC  = 3'd3;
  localparam logic [2:0] ALU_CLR  = 3'd4;

  // Single-bit field masks within the control word
  localparam logic [WORD_W-1:0] AR_WE      = 21'd1 << 16;
  localparam logic [WORD_W-1:0] PC_WE      = 21'd1 << 15;
  localparam logic [WORD_W-1:0] DR_WE      = 21'd1 << 14;
  localparam logic [WORD_W-1:0] IR_WE      = 21'd1 << 13;
  localparam logic [WORD_W-1:0] AC_WE      = 21'd1 << 12;
  localparam logic [WORD_W-1:0] R1_WE      = 21'd1 << 11;
  localparam logic [WORD_W-1:0] MEM_RD     = 21'd1 << 8;
  localparam logic [WORD_W-1:0] MEM_WR     = 21'd1 << 7;
  localparam logic [WORD_W-1:0] PC_INC     = 21'd1 << 6;
  localparam logic [WORD_W-1:0] AC_SRC_ALU = 21'd1 << 1;
  localparam logic [WORD_W-1:0] HALT       = 21'd1 << 0;

  // Place a bus source code into its field
  function automatic logic [WORD_W-1:0] bus_field(input logic [3:0] src);
    return {src, 17'b0};
  endfunction

  // Place an ALU op into its field; ALU results always route into AC
  function automatic logic [WORD_W-1:0] alu_field(input logic [2:0] op);
    return {16'b0, op, 2'b0} | AC_SRC_ALU | AC_WE;
  endfunction

endpackage

// File: rtl/cu_word_rom.sv
// cu_word_rom
//   Combinational lookup from sequencer state to the 21-bit control word.
//   Ports:
//     state  in  5   current sequencer state
//     word   out 21  control word driven to datapath and memory
module cu_word_rom
  import cu_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  output logic [WORD_W-1:0]  word
);

  always_comb begin
    word = '0;
    case (state)
      S_FETCH1, S_LD1, S_ST1, S_JMP1: word = bus_field(BUS_PC) | AR_WE;
      S_FETCH2, S_LD2, S_ST2:
        word = bus_field(BUS_MEM) | DR_WE | MEM_RD | PC_INC;
      S_FETCH3: word = bus_field(BUS_DR) | IR_WE;
      S_LD3, S_ST3: word = bus_field(BUS_DR) | AR_WE;
      S_LD4, S_JMP2: word = bus_field(BUS_MEM) | DR_WE | MEM_RD;
      S_LD5: word = bus_field(BUS_DR) | AC_WE;
      S_ST4: word = bus_field(BUS_AC) | DR_WE;
      S_ST5: word = bus_field(BUS_DR) | MEM_WR;
      S_MVACR1: word = bus_field(BUS_AC) | R1_WE;
      S_MVR1AC: word = bus_field(BUS_R1) | AC_WE;
      // R1 is the second ALU operand and reaches the ALU over the bus
      S_ADD: word = bus_field(BUS_R1) | alu_field(ALU_ADD);
      S_SUB: word = bus_field(BUS_R1) | alu_field(ALU_SUB);
      // Increment and clear need no second operand, so the bus stays idle
      S_INCAC: word = alu_field(ALU_INC);
      S_CLAC: word = alu_field(ALU_CLR);
      S_JMP3: word = bus_field(BUS_DR) | PC_WE;
      S_HALT: word = HALT;
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/cu.sv
// cu
//   Hard-wired fetch/decode/execute sequencer. Moore machine: the control word
//   depends only on the state register; IR_Input is examined only in DECODE.
//   Ports:
//     clk                  in  1   rising-edge clock
//     reset                in  1   synchronous active-high reset to START
//     IR_Input             in  8   opcode held in the datapath IR
//     Main_Control_Signal  out 21  control word for the current state
module cu
  import cu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     IR_Input,
  output logic [WORD_W-1:0]   Main_Control_Signal
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_START;
    else       state <= next_state;
  end

  // Unlisted opcodes fall through to FETCH1, which makes them behave as NOP
  always_comb begin
    next_state = S_START;
    case (state)
      S_START:  next_state = S_FETCH1;
      S_FETCH1: next_state = S_FETCH2;
      S_FETCH2: next_state = S_FETCH3;
      S_FETCH3: next_state = S_DECODE;
      S_DECODE: begin
        case (IR_Input)
          OP_LDAC:   next_state = S_LD1;
          OP_STAC:   next_state = S_ST1;
          OP_MVACR1: next_state = S_MVACR1;
          OP_MVR1AC: next_state = S_MVR1AC;
          OP_ADD:    next_state = S_ADD;
          OP_SUB:    next_state = S_SUB;
          OP_INCAC:  next_state = S_INCAC;
          OP_CLAC:   next_state = S_CLAC;
          OP_JUMP:   next_state = S_JMP1;
          OP_END:    next_state = S_HALT;
          default:   next_state = S_FETCH1;
        endcase
      end
      S_LD1: next_state = S_LD2;
      S_LD2: next_state = S_LD3;
      S_LD3: next_state = S_LD4;
      S_LD4: next_state = S_LD5;
      S_ST1: next_state = S_ST2;
      S_ST2: next_state = S_ST3;
      S_ST3: next_state = S_ST4;
      S_ST4: next_state = S_ST5;
      S_JMP1: next_state = S_JMP2;
      S_JMP2: next_state = S_JMP3;
      S_HALT: next_state = S_HALT;
      S_LD5, S_ST5, S_MVACR1, S_MVR1AC, S_ADD, S_SUB, S_INCAC, S_CLAC, S_JMP3:
        next_state = S_FETCH1;
      default: next_state = S_START;
    endcase
  end

  cu_word_rom u_word_rom (
    .state (state),
    .word  (Main_Control_Signal)
  );

endmodule

// File: tb/tb_cu.sv
// tb_cu
//   Scoreboard bench for cu. Each stimulus step drives reset/IR_Input on the
//   falling edge and queues the control word expected after the next rising
//   edge; an independent monitor pops and compares one word per cycle.
module tb_cu;

  logic        clk;
  logic        reset;
  logic [7:0]  IR_Input;
  logic [20:0] Main_Control_Signal;

  logic [20:0] exp_q[$];
  int          tests_run;
  int          tests_failed;

  cu dut (
    .clk                 (clk),
    .reset               (reset),
    .IR_Input            (IR_Input),
    .Main_Control_Signal (Main_Control_Signal)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs ahead of the next rising edge and record the word due after it
  task automatic applyStimulus(input logic rst, input logic [7:0] ir,
                               input logic [20:0] expected);
    @(negedge clk);
    reset    = rst;
    IR_Input = ir;
    exp_q.push_back(expected);
  endtask

  // Non-DECODE cycle: IR_Input carries random junk that must be ignored
  task automatic idle(input logic [20:0] expected);
    applyStimulus(1'b0, 8'($urandom), expected);
  endtask

  // From FETCH1: walk FETCH2, FETCH3 and land in DECODE
  task automatic fetch_to_decode();
    idle(21'h0C4140);
    idle(21'h042000);
    idle(21'h000000);
  endtask

  // From DECODE: issue opcode then the remaining words of the instruction
  task automatic run_instr(input logic [7:0] op, input int n,
                           input logic [20:0] words [8]);
    applyStimulus(1'b0, op, words[0]);
    for (int i = 1; i < n; i++) idle(words[i]);
  endtask

  task automatic checkOutput(input string name, input logic [20:0] expected);
    tests_run++;
    if (Main_Control_Signal !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %06h expected %06h", name,
               Main_Control_Signal, expected);
    end
  endtask

  // Monitor: one control word per cycle, sampled away from the active edge
  initial begin
    logic [20:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput($sformatf("word#%0d", tests_run), e);
      end
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    IR_Input     = 8'h00;

    // Reset held two cycles, then the fetch sequence
    applyStimulus(1'b1, 8'h00, 21'h000000);
    applyStimulus(1'b1, 8'h00, 21'h000000);
    idle(21'h030000);
    fetch_to_decode();

    // LDAC
    run_instr(8'h01, 6, '{21'h030000, 21'h0C4140, 21'h050000, 21'h0C4100,
                          21'h041000, 21'h030000, 21'h0, 21'h0});
    fetch_to_decode();

    // ADD: single execute word then FETCH1
    run_instr(8'h05, 2, '{21'h081006, 21'h030000, 21'h0, 21'h0,
                          21'h0, 21'h0, 21'h0, 21'h0});
    fetch_to_decode();

    // STAC
    run_instr(8'h02, 6, '{21'h030000, 21'h0C4140, 21'h050000, 21'h064000,
                          21'h040080, 21'h030000, 21'h0, 21'h0});
    fetch_to_decode();

    // Register moves and remaining ALU ops
    run_instr(8'h03, 2, '{21'h060800, 21'h030000, 21'h0, 21'h0,
                          21'h0, 21'h0, 21'h0, 21'h0});
    fetch_to_decode();
    run_instr(8'h04, 2, '{21'h081000, 21'h030000, 21'h0, 21'h0,
                          21'h0, 21'h0, 21'h0, 21'h0});
    fetch_to_decode();
    run_instr(8'h06, 2, '{21'h08100A, 21'h030000, 21'h0, 21'h0,
                          21'h0, 21'h0, 21'h0, 21'h0});
    fetch_to_decode();
    run_instr(8'h07, 2, '{21'h00100E, 21'h030000, 21'h0, 21'h0,
                          21'h0, 21'h0, 21'h0, 21'h0});
    fetch_to_decode();
    run_instr(8'h08, 2, '{21'h001012, 21'h030000, 21'h0, 21'h0,
                          21'h0, 21'h0, 21'h0, 21'h0});
    fetch_to_decode();

    // JUMP
    run_instr(8'h09, 4, '{21'h030000, 21'h0C4100, 21'h048000, 21'h030000,
                          21'h0, 21'h0, 21'h0, 21'h0});
    fetch_to_decode();

    // NOP and an undefined opcode both go straight back to FETCH1
    applyStimulus(1'b0, 8'h00, 21'h030000);
    fetch_to_decode();
    applyStimulus(1'b0, 8'h7E, 21'h030000);
    fetch_to_decode();

    // END: halt word held, only reset escapes
    applyStimulus(1'b0, 8'hFF, 21'h000001);
    for (int i = 0; i < 10; i++) idle(21'h000001);
    applyStimulus(1'b1, 8'($urandom), 21'h000000);
    idle(21'h030000);
    fetch_to_decode();

    // Reset in the middle of LDAC (while in LD3)
    run_instr(8'h01, 3, '{21'h030000, 21'h0C4140, 21'h050000, 21'h0,
                          21'h0, 21'h0, 21'h0, 21'h0});
    applyStimulus(1'b1, 8'($urandom), 21'h000000);
    idle(21'h030000);
    idle(21'h0C4140);

    // Let the monitor drain the queue within a bounded number of cycles
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
